// File: rtl/arith_pkg.sv
// Shared types and constants for the 8.8 fixed-point arithmetic blocks.
package arith_pkg;

    localparam int FIX_W = 16;
    localparam logic [FIX_W-1:0] FIX_ONE = 16'h0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

endpackage

// File: rtl/fixed_adder.sv
// Combinational 16-bit unsigned 8.8 adder; the sum wraps and c reports the carry out.
module fixed_adder
    import arith_pkg::*;
(
    input  logic [FIX_W-1:0] a,
    input  logic [FIX_W-1:0] b,
    output logic [FIX_W-1:0] sum,
    output logic             c
);

    assign {c, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fixed_multi.sv
// Combinational 8.8 x 8.8 unsigned multiplier built from shift-add partials,
// each partial truncated to 8.8 before summation; ovf flags integer bits lost above 16.
module fixed_multi
    import arith_pkg::*;
(
    input  logic [FIX_W-1:0] a,
    input  logic [FIX_W-1:0] b,
    output logic [FIX_W-1:0] p,
    output logic             ovf
);

    logic [31:0] sum;
    logic [31:0] part;

    // Sum of per-bit partials of b, each aligned back to 8.8 and truncated.
    always_comb begin
        sum  = 32'd0;
        part = 32'd0;
        for (int i = 0; i < FIX_W; i++) begin
            part = ({16'd0, a} << i) >> 4'd8;
            if (b[i]) begin
                sum = sum + part;
            end else begin
                sum = sum;
            end
        end
        p   = sum[15:0];
        ovf = |sum[31:16];
    end

endmodule

// File: rtl/fixed_mac_seq.sv
// Multiply-accumulate sequencer: streams len operand pairs through a registered
// product stage into a wrapping 8.8 accumulator and hands back the sum and a sticky overflow.
module fixed_mac_seq
    import arith_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FIX_W-1:0] a,
    input  logic [FIX_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FIX_W-1:0] acc,
    output logic             ovf
);

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    mac_state_t       state;
    logic [LEN_W-1:0] job_len;
    logic [LEN_W-1:0] accept_cnt;
    logic [LEN_W-1:0] accum_cnt;
    logic [FIX_W-1:0] p;
    logic             p_ovf;
    logic             p_vld;

    logic [FIX_W-1:0] mul_p;
    logic             mul_ovf;
    logic [FIX_W-1:0] add_sum;
    logic             add_c;
    logic             accept;

    fixed_multi u_mul (
        .a   (a),
        .b   (b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    fixed_adder u_add (
        .a   (acc),
        .b   (p),
        .sum (add_sum),
        .c   (add_c)
    );

    // Status outputs decode straight from registered state; in_ready also looks at the accept count.
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign in_ready  = (state == RUN) && (accept_cnt < job_len);
    assign accept    = in_valid && in_ready;

    // FSM, counters, product stage and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            job_len    <= CNT_ZERO;
            accept_cnt <= CNT_ZERO;
            accum_cnt  <= CNT_ZERO;
            p          <= 16'h0000;
            p_ovf      <= 1'b0;
            p_vld      <= 1'b0;
            acc        <= 16'h0000;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p_vld <= 1'b0;
                    if (start) begin
                        job_len    <= len;
                        accept_cnt <= CNT_ZERO;
                        accum_cnt  <= CNT_ZERO;
                        acc        <= 16'h0000;
                        ovf        <= 1'b0;
                        state      <= (len == CNT_ZERO) ? DONE : RUN;
                    end
                end
                RUN: begin
                    p_vld <= accept;
                    if (accept) begin
                        p          <= mul_p;
                        p_ovf      <= mul_ovf;
                        accept_cnt <= accept_cnt + CNT_ONE;
                    end
                    // Accumulate one cycle behind the product register; the last add ends the job.
                    if (p_vld) begin
                        acc       <= add_sum;
                        ovf       <= ovf | p_ovf | add_c;
                        accum_cnt <= accum_cnt + CNT_ONE;
                        if ((accum_cnt + CNT_ONE) == job_len) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    p_vld <= 1'b0;
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    p_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mac_seq.sv
// Self-checking bench for fixed_mac_seq: directed jobs from the test plan plus random jobs
// compared against an arithmetic reference model of the multiply-accumulate.
module tb_fixed_mac_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      acc;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    fixed_mac_seq #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", nm, tag, obs, exp);
        end
    endtask

    // Reference product: every set bit k of y contributes floor(x * 2^k / 256).
    function automatic logic [16:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint tot;
        tot = 0;
        for (int k = 0; k < 16; k++) begin
            if (((y >> k) & 16'd1) == 16'd1) tot += (longint'(x) * (longint'(1) << k)) / 256;
        end
        return {(tot >= 65536) ? 1'b1 : 1'b0, 16'(tot % 65536)};
    endfunction

    task automatic job_expect(input int l, output logic [15:0] e_acc, output logic e_ovf);
        longint s;
        logic [16:0] m;
        s = 0;
        e_ovf = 1'b0;
        for (int i = 0; i < l; i++) begin
            m = ref_mul(qa[i], qb[i]);
            if (m[16]) e_ovf = 1'b1;
            s += longint'(m[15:0]);
            if (s >= 65536) begin
                e_ovf = 1'b1;
                s -= 65536;
            end
        end
        e_acc = 16'(s);
    endtask

    // One complete job: start, feed qa/qb with gaps, check latency, hold in DONE, handshake.
    task automatic run_job(input string nm, input int l, input int gap, input bit rnd_gap,
                           input int hold, output logic [15:0] got_acc, output logic got_ovf);
        logic [15:0] e_acc;
        logic        e_ovf;
        int          g;
        job_expect(l, e_acc, e_ovf);
        start = 1'b1;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
        check(nm, "busy_start", {31'd0, busy}, 32'd1);
        if (l == 0) begin
            check(nm, "in_ready_len0", {31'd0, in_ready}, 32'd0);
            check(nm, "out_valid_len0", {31'd0, out_valid}, 32'd1);
        end else begin
            check(nm, "out_valid_early", {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < l; i++) begin
                check(nm, "in_ready_run", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b1;
                a = qa[i];
                b = qb[i];
                tick();
                in_valid = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                if (i == l - 1) begin
                    check(nm, "in_ready_after_last", {31'd0, in_ready}, 32'd0);
                    check(nm, "out_valid_k1", {31'd0, out_valid}, 32'd0);
                    tick();
                    check(nm, "out_valid_k2", {31'd0, out_valid}, 32'd1);
                end else begin
                    g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
                    for (int j = 0; j < g; j++) begin
                        in_valid = 1'b0;
                        tick();
                        check(nm, "in_ready_gap", {31'd0, in_ready}, 32'd1);
                    end
                end
            end
        end
        check(nm, "acc", {16'd0, acc}, {16'd0, e_acc});
        check(nm, "ovf", {31'd0, ovf}, {31'd0, e_ovf});
        got_acc = acc;
        got_ovf = ovf;
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            len   = 8'd4;
            tick();
            start = 1'b0;
            check(nm, "hold_valid", {31'd0, out_valid}, 32'd1);
            check(nm, "hold_acc", {16'd0, acc}, {16'd0, e_acc});
            check(nm, "hold_ovf", {31'd0, ovf}, {31'd0, e_ovf});
        end
        // start coinciding with the handshake must not launch a job
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check(nm, "idle_out_valid", {31'd0, out_valid}, 32'd0);
        check(nm, "idle_busy", {31'd0, busy}, 32'd0);
        check(nm, "idle_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        logic [15:0] r_acc;
        logic        r_ovf;
        int          l;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = 16'h0000; b = 16'h0000; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset", "busy", {31'd0, busy}, 32'd0);
        check("reset", "in_ready", {31'd0, in_ready}, 32'd0);
        check("reset", "out_valid", {31'd0, out_valid}, 32'd0);
        check("reset", "acc", {16'd0, acc}, 32'd0);
        check("reset", "ovf", {31'd0, ovf}, 32'd0);

        qa = '{16'h0100, 16'h0080, 16'h0300};
        qb = '{16'h0200, 16'h0400, 16'h0100};
        run_job("t_three", 3, 0, 1'b0, 0, r_acc, r_ovf);
        check("t_three", "acc_const", {16'd0, r_acc}, 32'h0700);
        check("t_three", "ovf_const", {31'd0, r_ovf}, 32'd0);

        qa = '{16'h1000};
        qb = '{16'h1000};
        run_job("t_povf", 1, 0, 1'b0, 0, r_acc, r_ovf);
        check("t_povf", "acc_const", {16'd0, r_acc}, 32'h0000);
        check("t_povf", "ovf_const", {31'd0, r_ovf}, 32'd1);

        qa = '{16'hC000, 16'hC000};
        qb = '{16'h0100, 16'h0100};
        run_job("t_carry", 2, 0, 1'b0, 0, r_acc, r_ovf);
        check("t_carry", "acc_const", {16'd0, r_acc}, 32'h8000);
        check("t_carry", "ovf_const", {31'd0, r_ovf}, 32'd1);

        qa.delete();
        qb.delete();
        run_job("t_len0", 0, 0, 1'b0, 0, r_acc, r_ovf);
        check("t_len0", "acc_const", {16'd0, r_acc}, 32'h0000);
        check("t_len0", "ovf_const", {31'd0, r_ovf}, 32'd0);

        qa = '{16'h0200, 16'h0100};
        qb = '{16'h0200, 16'h0100};
        run_job("t_gaps", 2, 3, 1'b0, 5, r_acc, r_ovf);
        check("t_gaps", "acc_const", {16'd0, r_acc}, 32'h0500);
        check("t_gaps", "ovf_const", {31'd0, r_ovf}, 32'd0);

        // abort a job mid-stream with rst
        start = 1'b1;
        len   = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a        = 16'h0300;
        b        = 16'h0300;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("t_rst", "busy", {31'd0, busy}, 32'd0);
        check("t_rst", "in_ready", {31'd0, in_ready}, 32'd0);
        check("t_rst", "out_valid", {31'd0, out_valid}, 32'd0);
        check("t_rst", "acc", {16'd0, acc}, 32'd0);
        check("t_rst", "ovf", {31'd0, ovf}, 32'd0);
        qa = '{16'h0100};
        qb = '{16'h0100};
        run_job("t_after_rst", 1, 0, 1'b0, 0, r_acc, r_ovf);
        check("t_after_rst", "acc_const", {16'd0, r_acc}, 32'h0100);
        check("t_after_rst", "ovf_const", {31'd0, r_ovf}, 32'd0);

        for (int n = 0; n < 24; n++) begin
            qa.delete();
            qb.delete();
            l = int'($urandom_range(1, 7));
            for (int i = 0; i < l; i++) begin
                if (n % 2 == 0) begin
                    qa.push_back(16'($urandom_range(0, 16'h05ff)));
                    qb.push_back(16'($urandom_range(0, 16'h05ff)));
                end else begin
                    qa.push_back(16'($urandom));
                    qb.push_back(16'($urandom));
                end
            end
            run_job("t_rand", l, 0, 1'b1, int'($urandom_range(0, 3)), r_acc, r_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
